// File: rtl/alsu_core.sv
// alsu_core: registered arithmetic/logic/shift unit.
// Stage 1 registers every control and data input each cycle. Stage 2 computes
// out/leds from those registered copies, which puts results 2 edges after the
// inputs are applied. SHIFT and ROTATE act on the current out register.
// Optional build macro ALSU_LED_BLINK_EN: when defined, invalid cycles toggle
// leds between 0x0000 and 0xFFFF. When undefined, leds is tied to 0 and no
// toggle register exists.
module alsu_core #(
  parameter INPUT_PRIORITY = "A",
  parameter FULL_ADDER     = "ON"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  A,
  input  logic [2:0]  B,
  input  logic [2:0]  opcode,
  input  logic        cin,
  input  logic        serial_in,
  input  logic        direction,
  input  logic        red_op_A,
  input  logic        red_op_B,
  input  logic        bypass_A,
  input  logic        bypass_B,
  output logic [5:0]  out,
  output logic [15:0] leds
);

  localparam logic PRIO_B  = (INPUT_PRIORITY == "B");
  localparam logic USE_CIN = (FULL_ADDER == "ON");

  logic [2:0] r_A, r_B, r_opcode;
  logic       r_cin, r_serial_in, r_direction;
  logic       r_red_op_A, r_red_op_B, r_bypass_A, r_bypass_B;
  logic [5:0] r_out;

  logic [2:0] w_prio_op;
  logic       w_bypass;
  logic       w_invalid;
  logic [5:0] w_out_next;

  // Stage 1: capture every input each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_A         <= 3'd0;
      r_B         <= 3'd0;
      r_opcode    <= 3'd0;
      r_cin       <= 1'b0;
      r_serial_in <= 1'b0;
      r_direction <= 1'b0;
      r_red_op_A  <= 1'b0;
      r_red_op_B  <= 1'b0;
      r_bypass_A  <= 1'b0;
      r_bypass_B  <= 1'b0;
    end else begin
      r_A         <= A;
      r_B         <= B;
      r_opcode    <= opcode;
      r_cin       <= cin;
      r_serial_in <= serial_in;
      r_direction <= direction;
      r_red_op_A  <= red_op_A;
      r_red_op_B  <= red_op_B;
      r_bypass_A  <= bypass_A;
      r_bypass_B  <= bypass_B;
    end
  end

  // Stage 2 result: bypass beats invalid, invalid beats the opcode decode.
  always_comb begin
    w_prio_op  = PRIO_B ? r_B : r_A;
    w_bypass   = r_bypass_A | r_bypass_B;
    w_invalid  = (r_opcode == 3'd6) || (r_opcode == 3'd7) ||
                 ((r_red_op_A || r_red_op_B) && (r_opcode[2:1] != 2'b00));
    w_out_next = 6'd0;
    if (w_bypass) begin
      if (r_bypass_A && r_bypass_B) w_out_next = {3'b000, w_prio_op};
      else if (r_bypass_A)          w_out_next = {3'b000, r_A};
      else                          w_out_next = {3'b000, r_B};
    end else if (w_invalid) begin
      w_out_next = 6'd0;
    end else begin
      case (r_opcode)
        3'd0: begin
          if (r_red_op_A && r_red_op_B) w_out_next = {5'b00000, &w_prio_op};
          else if (r_red_op_A)          w_out_next = {5'b00000, &r_A};
          else if (r_red_op_B)          w_out_next = {5'b00000, &r_B};
          else                          w_out_next = {3'b000, r_A & r_B};
        end
        3'd1: begin
          if (r_red_op_A && r_red_op_B) w_out_next = {5'b00000, ^w_prio_op};
          else if (r_red_op_A)          w_out_next = {5'b00000, ^r_A};
          else if (r_red_op_B)          w_out_next = {5'b00000, ^r_B};
          else                          w_out_next = {3'b000, r_A ^ r_B};
        end
        3'd2: w_out_next = {3'b000, r_A} + {3'b000, r_B} + {5'b00000, r_cin & USE_CIN};
        3'd3: w_out_next = {3'b000, r_A} * {3'b000, r_B};
        3'd4: w_out_next = r_direction ? {r_out[4:0], r_serial_in}
                                       : {r_serial_in, r_out[5:1]};
        3'd5: w_out_next = r_direction ? {r_out[4:0], r_out[5]}
                                       : {r_out[0], r_out[5:1]};
        default: w_out_next = 6'd0;
      endcase
    end
  end

  // Stage 2 register for the result.
  always_ff @(posedge clk) begin
    if (rst) r_out <= 6'd0;
    else     r_out <= w_out_next;
  end

  assign out = r_out;

`ifdef ALSU_LED_BLINK_EN
  logic [15:0] r_leds;

  // Status word: toggles while the invalid branch is taken, clears otherwise.
  always_ff @(posedge clk) begin
    if (rst)                         r_leds <= 16'h0000;
    else if (!w_bypass && w_invalid) r_leds <= ~r_leds;
    else                             r_leds <= 16'h0000;
  end

  assign leds = r_leds;
`else
  assign leds = 16'h0000;
`endif

endmodule

// File: tb/tb_alsu_core.sv
// Bench for alsu_core with default parameters (priority A, full adder on).
// The driver applies one stimulus per cycle and pushes the expected out/leds
// for the edge that consumes it. The monitor pops one entry after every
// rising edge and compares it against the DUT outputs.
module tb_alsu_core;

  typedef struct packed {
    logic [2:0] a, b, op;
    logic       cin, sin, dir, ra, rb, ba, bb;
  } stim_t;

  typedef struct packed {
    logic [5:0]  out;
    logic [15:0] leds;
  } exp_t;

`ifdef ALSU_LED_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        clk = 1'b1;
  logic        rst;
  logic [2:0]  A, B, opcode;
  logic        cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
  logic [5:0]  out;
  logic [15:0] leds;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  stim_t       m_stage;
  int          m_out;
  logic [15:0] m_leds;

  alsu_core dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .opcode(opcode), .cin(cin),
    .serial_in(serial_in), .direction(direction), .red_op_A(red_op_A),
    .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .out(out), .leds(leds)
  );

  always #5 clk = ~clk;

  function automatic int and_red(input int v);
    return (v == 7) ? 1 : 0;
  endfunction

  function automatic int xor_red(input int v);
    return $countones(v[2:0]) % 2;
  endfunction

  // Advance the reference model by one rising edge.
  task automatic model_edge(input stim_t st, input bit r);
    int a, b, op, nxt;
    bit invalid;
    if (r) begin
      m_stage = '0;
      m_out   = 0;
      m_leds  = 16'h0000;
      return;
    end
    a  = int'(m_stage.a);
    b  = int'(m_stage.b);
    op = int'(m_stage.op);
    invalid = (op >= 6) || ((m_stage.ra || m_stage.rb) && op > 1);
    nxt = 0;
    if (m_stage.ba || m_stage.bb) begin
      nxt    = m_stage.ba ? a : b;
      m_leds = 16'h0000;
    end else if (invalid) begin
      nxt    = 0;
      m_leds = BLINK ? ~m_leds : 16'h0000;
    end else begin
      m_leds = 16'h0000;
      case (op)
        0: nxt = m_stage.ra ? and_red(a) : m_stage.rb ? and_red(b) : (a & b);
        1: nxt = m_stage.ra ? xor_red(a) : m_stage.rb ? xor_red(b) : (a ^ b);
        2: nxt = a + b + int'(m_stage.cin);
        3: nxt = a * b;
        4: nxt = m_stage.dir ? (m_out * 2 + int'(m_stage.sin)) % 64
                             : m_out / 2 + int'(m_stage.sin) * 32;
        5: nxt = m_stage.dir ? (m_out * 2) % 64 + m_out / 32
                             : m_out / 2 + (m_out % 2) * 32;
        default: nxt = 0;
      endcase
    end
    m_out   = nxt;
    m_stage = st;
  endtask

  task automatic drive(input stim_t st, input bit r);
    exp_t e;
    @(negedge clk);
    rst = r;
    A = st.a; B = st.b; opcode = st.op; cin = st.cin; serial_in = st.sin;
    direction = st.dir; red_op_A = st.ra; red_op_B = st.rb;
    bypass_A = st.ba; bypass_B = st.bb;
    model_edge(st, r);
    e.out  = 6'(m_out);
    e.leds = m_leds;
    exp_q.push_back(e);
  endtask

  function automatic stim_t mk(input int a, input int b, input int op,
                               input bit ci, input bit si, input bit di,
                               input bit ra, input bit rb, input bit ba, input bit bb);
    stim_t s;
    s.a = 3'(a); s.b = 3'(b); s.op = 3'(op);
    s.cin = ci; s.sin = si; s.dir = di; s.ra = ra; s.rb = rb; s.ba = ba; s.bb = bb;
    return s;
  endfunction

  // Monitor: one expected entry per rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL queue_empty at %0t: no expected entry for this edge", $time);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (out !== e.out) begin
        failures++;
        $display("FAIL out at %0t: got %b expected %b", $time, out, e.out);
      end
      checks++;
      if (leds !== e.leds) begin
        failures++;
        $display("FAIL leds at %0t: got %h expected %h", $time, leds, e.leds);
      end
    end
  end

  initial begin
    stim_t s;
    stim_t idle;
    m_stage = '0;
    m_out   = 0;
    m_leds  = 16'h0000;
    idle    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    drive(idle, 1'b1);
    drive(idle, 1'b1);
    // bypass both, bypass B only
    drive(mk(5, 2, 3, 0, 0, 0, 0, 0, 1, 1), 1'b0);
    drive(mk(5, 2, 3, 0, 0, 0, 0, 0, 0, 1), 1'b0);
    // logic and reductions
    drive(mk(6, 3, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    drive(mk(7, 0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b0);
    drive(mk(0, 5, 1, 0, 0, 0, 0, 1, 0, 0), 1'b0);
    drive(mk(7, 0, 0, 0, 0, 0, 1, 1, 0, 0), 1'b0);
    // arithmetic extremes
    drive(mk(7, 7, 2, 1, 0, 0, 0, 0, 0, 0), 1'b0);
    drive(mk(7, 7, 3, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    // preload 000101, shift left twice, rotate right
    drive(mk(5, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0);
    drive(mk(0, 0, 4, 0, 1, 1, 0, 0, 0, 0), 1'b0);
    drive(mk(0, 0, 4, 0, 1, 1, 0, 0, 0, 0), 1'b0);
    drive(mk(0, 0, 5, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    drive(mk(0, 0, 5, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    // invalid opcode held, then recovery
    drive(mk(1, 1, 6, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    drive(mk(1, 1, 6, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    drive(mk(1, 1, 6, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    drive(mk(3, 4, 2, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    // invalid reduction, bypass overriding invalid, mid-run reset
    drive(mk(3, 4, 2, 0, 0, 0, 1, 0, 0, 0), 1'b0);
    drive(mk(3, 4, 7, 0, 0, 0, 1, 0, 0, 0), 1'b0);
    drive(mk(3, 4, 7, 0, 0, 0, 0, 0, 0, 1), 1'b0);
    drive(mk(6, 6, 7, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    drive(mk(6, 6, 3, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    drive(idle, 1'b0);

    for (int i = 0; i < 600; i++) begin
      s.a   = 3'($urandom_range(0, 7));
      s.b   = 3'($urandom_range(0, 7));
      s.op  = 3'($urandom_range(0, 7));
      s.cin = 1'($urandom_range(0, 1));
      s.sin = 1'($urandom_range(0, 1));
      s.dir = 1'($urandom_range(0, 1));
      s.ra  = ($urandom_range(0, 4) == 0);
      s.rb  = ($urandom_range(0, 4) == 0);
      s.ba  = ($urandom_range(0, 7) == 0);
      s.bb  = ($urandom_range(0, 7) == 0);
      drive(s, ($urandom_range(0, 49) == 0));
    end

    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
